// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine
//   Weight-stationary N x N systolic matrix-vector engine. A weight matrix is
//   loaded one row per beat, then activation vectors are streamed through the
//   array. Each vector x yields out[c] = sum_r x[r] * W[r][c], wrapping modulo
//   2^ACC_W. Results leave in acceptance order, 2N cycles after acceptance plus
//   one cycle per stall cycle.
//
// Ports
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   w_valid/w_ready     weight row beat handshake, w_data = W[r][0..N-1]
//   in_valid/in_ready   activation vector handshake, in_data = x[0..N-1]
//   in_last             marks the final vector of a batch
//   out_valid/out_ready result handshake, out_data = out[0..N-1]
//   out_last            set on the result of the vector that carried in_last
//   busy                high whenever the controller is not IDLE
//
// Handshake semantics (all three channels): a transfer happens on a rising
// edge where valid and ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready may depend on valid combinationally
// only where noted (in IDLE a pending w_valid forces in_ready low).
module systolic_matmul_engine #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [N*DATA_W-1:0] w_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*ACC_W-1:0]  out_data,
    output logic                out_last,
    output logic                busy
);

    localparam int ROW_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ROW_W-1:0]  row_q;
    logic              weights_loaded_q;

    logic en;
    logic w_fire;
    logic in_fire;
    logic last_out_fire;

    // The whole pipeline advances together; it only holds when a result is
    // presented and not taken.
    assign en            = !(out_valid && !out_ready);
    assign w_fire        = w_valid && w_ready;
    assign in_fire       = in_valid && in_ready;
    assign last_out_fire = out_valid && out_ready && out_last;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_fire) begin
                    state_d = LOAD_W;
                end else if (in_fire) begin
                    state_d = in_last ? DRAIN : STREAM;
                end
            end
            LOAD_W: begin
                if (w_fire && (row_q == ROW_W'(N - 1))) begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (in_fire && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_out_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_ready  = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                w_ready  = 1'b1;
                // A weight beat wins over a vector offered in the same cycle.
                in_ready = weights_loaded_q && en && !w_valid;
                busy     = 1'b0;
            end
            LOAD_W: begin
                w_ready = 1'b1;
            end
            STREAM: begin
                in_ready = en;
            end
            DRAIN: begin
                in_ready = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Weight storage. Rows are only written from IDLE/LOAD_W, where the
    // pipeline is empty, so no in-flight vector ever sees a change.
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] w_q [N][N];

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q            <= '0;
            weights_loaded_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else if (w_fire) begin
            for (int c = 0; c < N; c++) begin
                w_q[row_q][c] <= w_data[c*DATA_W +: DATA_W];
            end
            if (row_q == ROW_W'(N - 1)) begin
                row_q            <= '0;
                weights_loaded_q <= 1'b1;
            end else begin
                row_q <= row_q + ROW_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Input skew: lane r passes through r+1 registers so row r of the array
    // sees its activation one cycle after row r-1 sees its own.
    // Bubbles enter as zero.
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] skew_out [N];

    for (genvar r = 0; r < N; r++) begin : g_skew
        logic signed [DATA_W-1:0] sr [r+1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) begin
                    sr[k] <= '0;
                end
            end else if (en) begin
                sr[0] <= in_fire ? in_data[r*DATA_W +: DATA_W] : '0;
                for (int k = 1; k <= r; k++) begin
                    sr[k] <= sr[k-1];
                end
            end
        end

        assign skew_out[r] = sr[r];
    end

    // ------------------------------------------------------------------
    // PE grid: activations travel right, partial sums travel down.
    // ------------------------------------------------------------------
    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] prod;
        prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return acc + ACC_W'(prod);
    endfunction

    logic signed [DATA_W-1:0] act_q  [N][N-1];
    logic signed [ACC_W-1:0]  psum_q [N][N];
    logic signed [DATA_W-1:0] pe_a   [N][N];

    always_comb begin
        for (int r = 0; r < N; r++) begin
            pe_a[r][0] = skew_out[r];
            for (int c = 1; c < N; c++) begin
                pe_a[r][c] = act_q[r][c-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    act_q[r][c] <= '0;
                end
                for (int c = 0; c < N; c++) begin
                    psum_q[r][c] <= '0;
                end
            end
        end else if (en) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    act_q[r][c] <= pe_a[r][c];
                end
            end
            for (int c = 0; c < N; c++) begin
                psum_q[0][c] <= mac('0, pe_a[0][c], w_q[0][c]);
            end
            for (int r = 1; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    psum_q[r][c] <= mac(psum_q[r-1][c], pe_a[r][c], w_q[r][c]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output deskew: column c leaves the array c cycles after column 0, so it
    // gets N-1-c extra registers to realign all lanes.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] desk_out [N];

    for (genvar c = 0; c < N; c++) begin : g_deskew
        localparam int D = N - 1 - c;
        if (D == 0) begin : g_pass
            assign desk_out[c] = psum_q[N-1][c];
        end else begin : g_delay
            logic signed [ACC_W-1:0] dr [D];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < D; k++) begin
                        dr[k] <= '0;
                    end
                end else if (en) begin
                    dr[0] <= psum_q[N-1][c];
                    for (int k = 1; k < D; k++) begin
                        dr[k] <= dr[k-1];
                    end
                end
            end

            assign desk_out[c] = dr[D-1];
        end
    end

    // ------------------------------------------------------------------
    // Valid/last tags ride a 2N-deep shift register that stays aligned with
    // the data wavefront, since both advance on the same enable.
    // ------------------------------------------------------------------
    logic [2*N-1:0] vld_q;
    logic [2*N-1:0] lst_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q     <= '0;
            lst_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            vld_q     <= {vld_q[2*N-2:0], in_fire};
            lst_q     <= {lst_q[2*N-2:0], in_fire && in_last};
            out_valid <= vld_q[2*N-1];
            out_last  <= lst_q[2*N-1];
            for (int c = 0; c < N; c++) begin
                out_data[c*ACC_W +: ACC_W] <= desk_out[c];
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
module tb_systolic_matmul_engine;

  localparam int N      = 2;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int LAT    = 2 * N;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic w_valid;
  logic w_ready;
  logic [N*DATA_W-1:0] w_data;
  logic in_valid;
  logic in_ready;
  logic [N*DATA_W-1:0] in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [N*ACC_W-1:0] out_data;
  logic out_last;
  logic busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_matmul_engine #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [N*ACC_W-1:0] act, input logic [N*ACC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int wm [N][N];
  int wrow = 0;

  function automatic logic [N*ACC_W-1:0] model_out(input logic [N*DATA_W-1:0] x);
    logic [N*ACC_W-1:0] res;
    logic signed [DATA_W-1:0] xs;
    longint s;
    res = '0;
    for (int c = 0; c < N; c++) begin
      s = 0;
      for (int r = 0; r < N; r++) begin
        xs = x[r*DATA_W +: DATA_W];
        s = s + longint'(xs) * longint'(wm[r][c]);
      end
      res[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
    end
    return res;
  endfunction

  // ---------------- scoreboard ----------------
  logic [N*ACC_W:0] exp_q[$];   // {last, data}
  int rem_q[$];                 // enabled edges still needed before the result shows
  int pop_cyc_q[$];
  int pop_cnt = 0;
  logic [N*ACC_W-1:0] last_out = '0;
  bit stall_prev = 1'b0;
  logic [N*ACC_W-1:0] stall_data = '0;

  always @(negedge clk) begin
    logic signed [DATA_W-1:0] wv;
    logic en_m;
    logic [N*ACC_W:0] e;
    if (reset) begin
      exp_q.delete();
      rem_q.delete();
      for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) wm[r][c] = 0;
      wrow = 0;
      stall_prev = 1'b0;
    end else begin
      en_m = !(out_valid && !out_ready);
      if (stall_prev) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, stall_data);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;

      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_without_pending", out_valid, 0);
        end else begin
          check("latency_early", rem_q[0], 0);
          if (out_ready) begin
            e = exp_q.pop_front();
            void'(rem_q.pop_front());
            check("out_data", out_data, e[N*ACC_W-1:0]);
            check("out_last", out_last, e[N*ACC_W]);
            last_out = out_data;
            pop_cnt++;
            pop_cyc_q.push_back(cyc);
          end
        end
      end else if (rem_q.size() > 0 && rem_q[0] == 0) begin
        check("latency_late", out_valid, 1);
      end

      if (en_m) begin
        for (int i = 0; i < rem_q.size(); i++) if (rem_q[i] > 0) rem_q[i] = rem_q[i] - 1;
      end

      if (w_valid && w_ready) begin
        for (int c = 0; c < N; c++) begin
          wv = w_data[c*DATA_W +: DATA_W];
          wm[wrow][c] = int'(wv);
        end
        wrow = (wrow == N - 1) ? 0 : wrow + 1;
      end

      if (in_valid && in_ready) begin
        exp_q.push_back({in_last, model_out(in_data)});
        rem_q.push_back(LAT);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [N*N*DATA_W-1:0] pack4(input int w00, input int w01, input int w10, input int w11);
    logic [N*N*DATA_W-1:0] m;
    m[0 +: 16]  = 16'(w00);
    m[16 +: 16] = 16'(w01);
    m[32 +: 16] = 16'(w10);
    m[48 +: 16] = 16'(w11);
    return m;
  endfunction

  function automatic logic [N*DATA_W-1:0] vec2(input int x0, input int x1);
    logic [N*DATA_W-1:0] v;
    v[0 +: 16]  = 16'(x0);
    v[16 +: 16] = 16'(x1);
    return v;
  endfunction

  function automatic logic [N*ACC_W-1:0] lit2(input longint a, input longint b);
    logic [N*ACC_W-1:0] r;
    r[0 +: ACC_W]     = a[ACC_W-1:0];
    r[ACC_W +: ACC_W] = b[ACC_W-1:0];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_lane();
    return ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
  endfunction

  function automatic logic [N*N*DATA_W-1:0] rand_mat();
    logic [N*N*DATA_W-1:0] m;
    for (int k = 0; k < N * N; k++) m[k*DATA_W +: DATA_W] = rand_lane();
    return m;
  endfunction

  function automatic logic [N*DATA_W-1:0] rand_vec();
    logic [N*DATA_W-1:0] v;
    for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = rand_lane();
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  bit rnd_ready = 1'b0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic send_w_row(input logic [N*DATA_W-1:0] row);
    logic ok;
    int waited;
    ok = 1'b0;
    waited = 0;
    w_valid = 1'b1;
    w_data = row;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = w_ready;
      @(posedge clk);
      #1;
      if (!ok) waited++;
    end
    w_valid = 1'b0;
    check("w_accept", ok, 1);
  endtask

  task automatic load_w(input logic [N*N*DATA_W-1:0] mat, input bit gaps);
    for (int r = 0; r < N; r++) begin
      send_w_row(mat[r*N*DATA_W +: N*DATA_W]);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_vec(input logic [N*DATA_W-1:0] x, input logic last, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_data = x;
    in_last = last;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) waited++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("in_accept", ok, 1);
  endtask

  task automatic wait_pop(input int target);
    int n;
    n = 0;
    while (pop_cnt < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pop_timeout", pop_cnt, target);
  endtask

  task automatic wait_idle();
    logic done;
    int n;
    done = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy;
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", done, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wt;
    int base;
    int acc_cyc;
    int nvec;
    reset = 1'b1;
    w_valid = 1'b0;
    w_data = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_w_ready", w_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, '0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // basic product, literal result and latency
    load_w(pack4(1, 2, 3, 4), 1'b1);
    base = pop_cnt;
    send_vec(vec2(5, 6), 1'b1, wt);
    acc_cyc = cyc;
    wait_pop(base + 1);
    check("t1_lit", last_out, lit2(23, 34));
    check("t1_latency", pop_cyc_q[pop_cyc_q.size()-1] - acc_cyc, LAT);
    @(negedge clk);
    check("t1_idle", busy, 0);
    @(posedge clk);
    #1;

    // negative activations, then largest-magnitude products
    base = pop_cnt;
    send_vec(vec2(-1, 2), 1'b1, wt);
    wait_pop(base + 1);
    check("t2_neg_lit", last_out, lit2(5, 6));
    load_w(pack4(-32768, -32768, -32768, -32768), 1'b0);
    base = pop_cnt;
    send_vec(vec2(-32768, -32768), 1'b1, wt);
    wait_pop(base + 1);
    check("t2_max_lit", last_out, lit2(64'sd2147483648, 64'sd2147483648));
    wait_idle();

    // back-to-back stream without backpressure
    load_w(rand_mat(), 1'b0);
    pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      send_vec(rand_vec(), (i == 7), wt);
      check("t3_in_ready_wait", wt, 0);
    end
    wait_idle();
    check("t3_count", pop_cyc_q.size(), 8);
    for (int i = 0; i + 1 < pop_cyc_q.size(); i++)
      check("t3_gap", pop_cyc_q[i+1] - pop_cyc_q[i], 1);

    // random backpressure, random data, occasional reloads
    rnd_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      if (b > 0 && $urandom_range(0, 1) == 1) load_w(rand_mat(), 1'b1);
      nvec = $urandom_range(4, 10);
      for (int i = 0; i < nvec; i++) begin
        send_vec(rand_vec(), (i == nvec - 1), wt);
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
      wait_idle();
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // weight beat has priority over a vector in IDLE; reload identity
    w_valid = 1'b1;
    w_data = vec2(1, 0);
    in_valid = 1'b1;
    in_data = vec2(11, 12);
    in_last = 1'b0;
    @(negedge clk);
    check("t5_w_ready", w_ready, 1);
    check("t5_in_blocked", in_ready, 0);
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_load", busy, 1);
    @(posedge clk);
    #1;
    send_w_row(vec2(0, 1));
    base = pop_cnt;
    send_vec(vec2(7, 9), 1'b1, wt);
    wait_pop(base + 1);
    check("t5_ident_lit", last_out, lit2(7, 9));
    wait_idle();

    // reset with vectors in flight
    load_w(rand_mat(), 1'b0);
    for (int i = 0; i < 3; i++) send_vec(rand_vec(), 1'b0, wt);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = rand_vec();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t6_no_out", out_valid, 0);
      check("t6_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    load_w(pack4(1, 0, 0, 1), 1'b0);
    @(negedge clk);
    check("t6_in_ready_after_load", in_ready, 1);
    @(posedge clk);
    #1;
    send_vec(vec2(3, -4), 1'b1, wt);
    wait_idle();
    check("t6_last_lit", last_out, lit2(3, -4));

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog actual=running expected=finished (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
